// File: rtl/cpu_pkg.sv
// Shared encodings for the RISC CPU control unit: opcodes, FSM states and
// instruction classes.
package cpu_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10101;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // ALU select used for effective-address and branch-target adds
  localparam logic [4:0] ALU_ADD = 5'b00011;

  typedef enum logic [3:0] {
    StRst, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7, StHalt
  } cu_state_e;

  typedef enum logic [3:0] {
    ClsAlu, ClsImm, ClsUnary, ClsMulDiv, ClsLd, ClsLdi, ClsSt,
    ClsBr, ClsJr, ClsMfhi, ClsMflo, ClsNop, ClsHalt
  } instr_class_e;

endpackage

// File: rtl/control_unit_if.sv
// Strobe/status bundle between control_unit (master) and DataPath (slave).
// mem_ready exists only when CU_MEM_WAIT_EN is defined.
interface control_unit_if;
  logic [31:0] ir;
  logic        con_ff;
`ifdef CU_MEM_WAIT_EN
  logic        mem_ready;
`endif
  logic PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Cout, BAout, Rout;
  logic MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn, Rin, CONin;
  logic Gra, Grb, Grc;
  logic IncPC, Read, Write;
  logic [4:0] alu_op;
  logic run;

  modport master (
    input  ir, con_ff,
`ifdef CU_MEM_WAIT_EN
    input  mem_ready,
`endif
    output PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Cout, BAout, Rout,
    output MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn, Rin, CONin,
    output Gra, Grb, Grc, IncPC, Read, Write, alu_op, run
  );

  modport slave (
    output ir, con_ff,
`ifdef CU_MEM_WAIT_EN
    output mem_ready,
`endif
    input  PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Cout, BAout, Rout,
    input  MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn, Rin, CONin,
    input  Gra, Grb, Grc, IncPC, Read, Write, alu_op, run
  );
endinterface

// File: rtl/cu_decode.sv
// Combinational opcode -> instruction class mapping.
module cu_decode
  import cpu_pkg::*;
(
  input  logic [4:0]   opcode_i,
  output instr_class_e cls_o
);

  // Unlisted opcodes fall through to ClsNop
  always_comb begin
    cls_o = ClsNop;
    case (opcode_i) inside
      [OP_ADD:OP_SHL]:  cls_o = ClsAlu;
      [OP_ADDI:OP_ORI]: cls_o = ClsImm;
      OP_NEG, OP_NOT:   cls_o = ClsUnary;
      OP_MUL, OP_DIV:   cls_o = ClsMulDiv;
      OP_LD:            cls_o = ClsLd;
      OP_LDI:           cls_o = ClsLdi;
      OP_ST:            cls_o = ClsSt;
      OP_BR:            cls_o = ClsBr;
      OP_JR:            cls_o = ClsJr;
      OP_MFHI:          cls_o = ClsMfhi;
      OP_MFLO:          cls_o = ClsMflo;
      OP_HALT:          cls_o = ClsHalt;
      default:          cls_o = ClsNop;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired sequencer for the RISC CPU DataPath: fetch T0-T2, opcode-dependent
// execute T3-T7, Moore-decoded strobes. Optional CU_MEM_WAIT_EN adds mem_ready
// stalls on the memory steps.
module control_unit
  import cpu_pkg::*;
(
  input logic            clock,
  input logic            clear,
  control_unit_if.master cu
);

  cu_state_e    state_q, state_d;
  instr_class_e cls;
  logic [4:0]   opcode;
  logic         mem_rdy;

  assign opcode = cu.ir[31:27];

`ifdef CU_MEM_WAIT_EN
  assign mem_rdy = cu.mem_ready;
`else
  assign mem_rdy = 1'b1;
`endif

  cu_decode u_decode (
    .opcode_i (opcode),
    .cls_o    (cls)
  );

  // State register; clear aborts any instruction and parks in StRst
  always_ff @(posedge clock) begin
    if (clear) state_q <= StRst;
    else       state_q <= state_d;
  end

  // Next-state and strobe decode from state and the latched IR
  always_comb begin
    state_d     = state_q;
    cu.PCout    = 1'b0; cu.Zhighout = 1'b0; cu.Zlowout = 1'b0; cu.MDRout  = 1'b0;
    cu.HIout    = 1'b0; cu.LOout    = 1'b0; cu.Cout    = 1'b0; cu.BAout   = 1'b0;
    cu.Rout     = 1'b0; cu.MARin    = 1'b0; cu.PCin    = 1'b0; cu.MDRin   = 1'b0;
    cu.IRin     = 1'b0; cu.Yin      = 1'b0; cu.HIin    = 1'b0; cu.LOin    = 1'b0;
    cu.ZHighIn  = 1'b0; cu.ZLowIn   = 1'b0; cu.Rin     = 1'b0; cu.CONin   = 1'b0;
    cu.Gra      = 1'b0; cu.Grb      = 1'b0; cu.Grc     = 1'b0; cu.IncPC   = 1'b0;
    cu.Read     = 1'b0; cu.Write    = 1'b0;
    cu.alu_op   = 5'b00000;
    cu.run      = (state_q != StRst) && (state_q != StHalt);

    case (state_q)
      StRst: state_d = StT0;
      StT0: begin
        cu.PCout = 1'b1; cu.MARin = 1'b1; cu.IncPC = 1'b1;
        state_d = StT1;
      end
      StT1: begin
        cu.Read = 1'b1; cu.MDRin = 1'b1;
        if (mem_rdy) state_d = StT2;
      end
      StT2: begin
        cu.MDRout = 1'b1; cu.IRin = 1'b1;
        if (cls == ClsNop)       state_d = StT0;
        else if (cls == ClsHalt) state_d = StHalt;
        else                     state_d = StT3;
      end
      StT3: begin
        state_d = StT4;
        case (cls)
          ClsAlu, ClsImm, ClsUnary: begin cu.Grb = 1'b1; cu.Rout = 1'b1; cu.Yin = 1'b1; end
          ClsMulDiv:                begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.Yin = 1'b1; end
          ClsLd, ClsLdi, ClsSt:     begin cu.Grb = 1'b1; cu.BAout = 1'b1; cu.Yin = 1'b1; end
          ClsBr: begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.CONin = 1'b1; end
          ClsJr: begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.PCin = 1'b1; state_d = StT0; end
          ClsMfhi: begin cu.HIout = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1; state_d = StT0; end
          ClsMflo: begin cu.LOout = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1; state_d = StT0; end
          default: state_d = StT0;
        endcase
      end
      StT4: begin
        state_d = StT5;
        case (cls)
          ClsAlu:   begin cu.Grc = 1'b1; cu.Rout = 1'b1; cu.alu_op = opcode; cu.ZLowIn = 1'b1; end
          ClsImm:   begin cu.Cout = 1'b1; cu.alu_op = opcode; cu.ZLowIn = 1'b1; end
          ClsUnary: begin cu.alu_op = opcode; cu.ZLowIn = 1'b1; end
          ClsMulDiv: begin
            cu.Grb = 1'b1; cu.Rout = 1'b1; cu.alu_op = opcode;
            cu.ZHighIn = 1'b1; cu.ZLowIn = 1'b1;
          end
          ClsLd, ClsLdi, ClsSt: begin cu.Cout = 1'b1; cu.alu_op = ALU_ADD; cu.ZLowIn = 1'b1; end
          ClsBr:   begin cu.PCout = 1'b1; cu.Yin = 1'b1; end
          default: state_d = StT0;
        endcase
      end
      StT5: begin
        state_d = StT6;
        case (cls)
          ClsAlu, ClsImm, ClsUnary, ClsLdi: begin
            cu.Zlowout = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1; state_d = StT0;
          end
          ClsMulDiv:    begin cu.Zlowout = 1'b1; cu.LOin = 1'b1; end
          ClsLd, ClsSt: begin cu.Zlowout = 1'b1; cu.MARin = 1'b1; end
          ClsBr:        begin cu.Cout = 1'b1; cu.alu_op = ALU_ADD; cu.ZLowIn = 1'b1; end
          default:      state_d = StT0;
        endcase
      end
      StT6: begin
        state_d = StT0;
        case (cls)
          ClsMulDiv: begin cu.Zhighout = 1'b1; cu.HIin = 1'b1; end
          ClsLd: begin
            cu.Read = 1'b1; cu.MDRin = 1'b1;
            state_d = mem_rdy ? StT7 : StT6;
          end
          ClsSt: begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.MDRin = 1'b1; state_d = StT7; end
          ClsBr: begin cu.PCin = cu.con_ff; cu.Zlowout = cu.con_ff; end
          default: ;
        endcase
      end
      StT7: begin
        state_d = StT0;
        case (cls)
          ClsLd: begin cu.MDRout = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1; end
          ClsSt: begin
            cu.Write = 1'b1;
            if (!mem_rdy) state_d = StT7;
          end
          default: ;
        endcase
      end
      StHalt:  state_d = StHalt;
      default: state_d = StRst;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-instruction expected strobe vectors are
// queued when the instruction is set up and popped/compared once per cycle.
module tb_control_unit;

  logic clk = 1'b0;
  logic clear;
  always #5 clk = ~clk;

  control_unit_if cu_bus ();

  control_unit dut (
    .clock (clk),
    .clear (clear),
    .cu    (cu_bus)
  );

  // Observed vector: {run, alu_op, 9 bus drivers, 11 enables, Gra/b/c, IncPC/Read/Write}
  localparam logic [31:0] WRITE = 32'h1 << 0,  READ   = 32'h1 << 1,  INCPC  = 32'h1 << 2;
  localparam logic [31:0] GRC   = 32'h1 << 3,  GRB    = 32'h1 << 4,  GRA    = 32'h1 << 5;
  localparam logic [31:0] CONIN = 32'h1 << 6,  RIN    = 32'h1 << 7,  ZLOWIN = 32'h1 << 8;
  localparam logic [31:0] ZHIIN = 32'h1 << 9,  LOIN   = 32'h1 << 10, HIIN   = 32'h1 << 11;
  localparam logic [31:0] YIN   = 32'h1 << 12, IRIN   = 32'h1 << 13, MDRIN  = 32'h1 << 14;
  localparam logic [31:0] PCIN  = 32'h1 << 15, MARIN  = 32'h1 << 16, ROUT   = 32'h1 << 17;
  localparam logic [31:0] BAOUT = 32'h1 << 18, COUT   = 32'h1 << 19, LOOUT  = 32'h1 << 20;
  localparam logic [31:0] HIOUT = 32'h1 << 21, MDROUT = 32'h1 << 22, ZLOOUT = 32'h1 << 23;
  localparam logic [31:0] ZHOUT = 32'h1 << 24, PCOUT  = 32'h1 << 25, RUN    = 32'h1 << 31;

  logic [31:0] obs;
  assign obs = {cu_bus.run, cu_bus.alu_op,
                cu_bus.PCout, cu_bus.Zhighout, cu_bus.Zlowout, cu_bus.MDRout, cu_bus.HIout,
                cu_bus.LOout, cu_bus.Cout, cu_bus.BAout, cu_bus.Rout,
                cu_bus.MARin, cu_bus.PCin, cu_bus.MDRin, cu_bus.IRin, cu_bus.Yin, cu_bus.HIin,
                cu_bus.LOin, cu_bus.ZHighIn, cu_bus.ZLowIn, cu_bus.Rin, cu_bus.CONin,
                cu_bus.Gra, cu_bus.Grb, cu_bus.Grc, cu_bus.IncPC, cu_bus.Read, cu_bus.Write};

  logic [31:0] q[$];
  int checks = 0;
  int errors = 0;
  int cyc_idx = 0;

  function automatic logic [31:0] alu(input logic [4:0] op);
    return {1'b0, op, 26'b0};
  endfunction

  // Expected per-cycle vectors for one instruction, T0 through its last step
  task automatic push_instr(input logic [4:0] op, input logic con);
    q.push_back(RUN | PCOUT | MARIN | INCPC);
    q.push_back(RUN | READ | MDRIN);
    q.push_back(RUN | MDROUT | IRIN);
    if (op >= 5'd3 && op <= 5'd11) begin
      q.push_back(RUN | GRB | ROUT | YIN);
      q.push_back(RUN | GRC | ROUT | ZLOWIN | alu(op));
      q.push_back(RUN | ZLOOUT | GRA | RIN);
    end else if (op >= 5'd12 && op <= 5'd14) begin
      q.push_back(RUN | GRB | ROUT | YIN);
      q.push_back(RUN | COUT | ZLOWIN | alu(op));
      q.push_back(RUN | ZLOOUT | GRA | RIN);
    end else if (op == 5'd17 || op == 5'd18) begin
      q.push_back(RUN | GRB | ROUT | YIN);
      q.push_back(RUN | ZLOWIN | alu(op));
      q.push_back(RUN | ZLOOUT | GRA | RIN);
    end else if (op == 5'd15 || op == 5'd16) begin
      q.push_back(RUN | GRA | ROUT | YIN);
      q.push_back(RUN | GRB | ROUT | ZHIIN | ZLOWIN | alu(op));
      q.push_back(RUN | ZLOOUT | LOIN);
      q.push_back(RUN | ZHOUT | HIIN);
    end else if (op <= 5'd2) begin
      q.push_back(RUN | GRB | BAOUT | YIN);
      q.push_back(RUN | COUT | ZLOWIN | alu(5'b00011));
      if (op == 5'd1) begin
        q.push_back(RUN | ZLOOUT | GRA | RIN);
      end else begin
        q.push_back(RUN | ZLOOUT | MARIN);
        if (op == 5'd0) begin
          q.push_back(RUN | READ | MDRIN);
          q.push_back(RUN | MDROUT | GRA | RIN);
        end else begin
          q.push_back(RUN | GRA | ROUT | MDRIN);
          q.push_back(RUN | WRITE);
        end
      end
    end else if (op == 5'd19) begin
      q.push_back(RUN | GRA | ROUT | CONIN);
      q.push_back(RUN | PCOUT | YIN);
      q.push_back(RUN | COUT | ZLOWIN | alu(5'b00011));
      q.push_back(con ? (RUN | PCIN | ZLOOUT) : RUN);
    end else if (op == 5'd21) begin
      q.push_back(RUN | GRA | ROUT | PCIN);
    end else if (op == 5'd24) begin
      q.push_back(RUN | HIOUT | GRA | RIN);
    end else if (op == 5'd25) begin
      q.push_back(RUN | LOOUT | GRA | RIN);
    end
    // nop, halt and unlisted opcodes: fetch only
  endtask

  task automatic check_one(input string tag);
    logic [31:0] exp;
    @(negedge clk);
    checks++;
    if (q.size() == 0) begin
      errors++;
      $error("FAIL %s cycle %0d: observed %h expected <empty scoreboard>", tag, cyc_idx, obs);
    end else begin
      exp = q.pop_front();
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc_idx, obs, exp);
      end
    end
    cyc_idx++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    cyc_idx = 0;
    while (q.size() > 0) begin
      check_one(tag);
      step();
    end
  endtask

  // Load ir just after entering T0, queue expectations, compare every cycle
  task automatic run_op(input logic [4:0] op, input logic con, input string tag);
    cu_bus.ir     = {op, 27'h0123456};
    cu_bus.con_ff = con;
    push_instr(op, con);
    drain(tag);
  endtask

  initial begin
    clear         = 1'b1;
    cu_bus.ir     = 32'h0;
    cu_bus.con_ff = 1'b0;
`ifdef CU_MEM_WAIT_EN
    cu_bus.mem_ready = 1'b1;
`endif
    step();
    step();
    q.push_back(32'h0);
    cyc_idx = 0;
    check_one("reset");
    clear = 1'b0;
    step();

    // neg via the full IR word from the test plan
    cu_bus.ir = 32'h8A1B8000;
    push_instr(5'b10001, 1'b0);
    drain("neg");

    run_op(5'b00011, 1'b0, "add");
    run_op(5'b01010, 1'b0, "shra");
    run_op(5'b01100, 1'b0, "addi");
    run_op(5'b10010, 1'b0, "not");
    run_op(5'b00000, 1'b0, "ld");
    run_op(5'b00001, 1'b0, "ldi");
    run_op(5'b00010, 1'b0, "st");
    run_op(5'b10011, 1'b0, "br_con0");
    run_op(5'b10011, 1'b1, "br_con1");
    run_op(5'b01111, 1'b0, "div");
    run_op(5'b10000, 1'b0, "mul");
    run_op(5'b10101, 1'b0, "jr");
    run_op(5'b11000, 1'b0, "mfhi");
    run_op(5'b11001, 1'b0, "mflo");
    run_op(5'b11010, 1'b0, "nop");
    run_op(5'b10100, 1'b0, "unlisted");

    // halt: fetch, then 10 idle cycles with run low
    cu_bus.ir = {5'b11011, 27'h0};
    push_instr(5'b11011, 1'b0);
    repeat (10) q.push_back(32'h0);
    drain("halt");
    clear = 1'b1;
    q.push_back(32'h0);
    check_one("halt_hold");
    step();
    clear = 1'b0;
    q.push_back(32'h0);
    check_one("halt_clear_rst");
    step();
    run_op(5'b11000, 1'b0, "after_halt");

    // clear during mul T5 aborts to RST, fetch restarts
    cu_bus.ir = {5'b10000, 27'h0};
    push_instr(5'b10000, 1'b0);
    cyc_idx = 0;
    repeat (5) begin
      check_one("mul_abort_pre");
      step();
    end
    check_one("mul_abort_t5");
    q.delete();
    clear = 1'b1;
    step();
    clear = 1'b0;
    q.push_back(32'h0);
    check_one("mul_abort_rst");
    step();
    run_op(5'b10101, 1'b0, "after_abort");

`ifdef CU_MEM_WAIT_EN
    // mem_ready low for three T1 cycles stretches the fetch read
    cu_bus.ir = {5'b11010, 27'h0};
    q.push_back(RUN | PCOUT | MARIN | INCPC);
    repeat (4) q.push_back(RUN | READ | MDRIN);
    q.push_back(RUN | MDROUT | IRIN);
    cu_bus.mem_ready = 1'b0;
    cyc_idx = 0;
    check_one("mem_wait");
    step();
    repeat (3) begin
      check_one("mem_wait");
      step();
    end
    cu_bus.mem_ready = 1'b1;
    while (q.size() > 0) begin
      check_one("mem_wait");
      step();
    end
    run_op(5'b11001, 1'b0, "after_wait");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
